// File: rtl/multi_debouncer_if.sv
// multi_debouncer_if: raw button inputs and debounced level/pulse outputs.
interface multi_debouncer_if #(parameter int CHANNELS = 4);
    logic [CHANNELS-1:0] pb;
    logic [CHANNELS-1:0] db_level;
    logic [CHANNELS-1:0] press_p;
    logic [CHANNELS-1:0] release_p;
    logic                any_press;
    modport master (output pb, input db_level, press_p, release_p, any_press);
    modport slave  (input pb, output db_level, press_p, release_p, any_press);
endinterface

// File: rtl/multi_debouncer.sv
// multi_debouncer: independent per-channel push-button debouncers with
// registered level, press and release pulse outputs.
module multi_debouncer #(
    parameter int CHANNELS    = 4,
    parameter int DELAY       = 350_000,
    parameter int CNT_W       = 20,
    parameter bit ACTIVE_HIGH = 1
) (
    input logic clk,
    input logic rst_n,
    multi_debouncer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
    localparam logic [CNT_W-1:0]    RELOAD   = CNT_W'(DELAY - 1);
    localparam logic [CHANNELS-1:0] IDLE_LVL = ACTIVE_HIGH ? '0 : '1;
    logic [CHANNELS-1:0] sync1, sync2, act, press_d, release_d, level_d;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= bus.pb;
            sync2 <= sync1;
        end
    assign act = ACTIVE_HIGH ? sync2 : ~sync2;
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state, state_n;
        logic [CNT_W-1:0] cnt, cnt_n;
        logic             zero;
        assign zero = cnt == '0;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
            end
        // Wait states reload on entry and only count down while nonzero.
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            case (state)
                IDLE:         if (act[g]) begin state_n = PRESS_WAIT; cnt_n = RELOAD; end
                PRESS_WAIT:   state_n = !act[g] ? IDLE : zero ? PRESSED : PRESS_WAIT;
                PRESSED:      if (!act[g]) begin state_n = RELEASE_WAIT; cnt_n = RELOAD; end
                RELEASE_WAIT: state_n = act[g] ? PRESSED : zero ? IDLE : RELEASE_WAIT;
                default:      state_n = IDLE;
            endcase
            if ((state == PRESS_WAIT || state == RELEASE_WAIT) && state_n == state && !zero)
                cnt_n = cnt - CNT_W'(1);
        end
        assign press_d[g]   = state == PRESS_WAIT && act[g] && zero;
        assign release_d[g] = state == RELEASE_WAIT && !act[g] && zero;
        assign level_d[g]   = state_n == PRESSED || state_n == RELEASE_WAIT;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.db_level  <= '0;
            bus.press_p   <= '0;
            bus.release_p <= '0;
            bus.any_press <= 1'b0;
        end else begin
            bus.db_level  <= level_d;
            bus.press_p   <= press_d;
            bus.release_p <= release_d;
            bus.any_press <= |press_d;
        end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed checks of latency, glitch rejection, release
// handling, simultaneous presses and reset for both button polarities.
module tb_multi_debouncer;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int checks = 0, passed = 0;
    int np, nr, db_lo, db_hi;
    multi_debouncer_if #(.CHANNELS(4)) bus_a ();
    multi_debouncer_if #(.CHANNELS(4)) bus_b ();
    multi_debouncer #(.CHANNELS(4), .DELAY(4), .CNT_W(3), .ACTIVE_HIGH(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(bus_a));
    multi_debouncer #(.CHANNELS(4), .DELAY(4), .CNT_W(3), .ACTIVE_HIGH(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(bus_b));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask
    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.pb = 4'b0000;
        bus_b.pb = 4'b1111;
        repeat (3) tick();
        chk("rst_db", bus_a.db_level, 4'b0000);
        chk("rst_press", bus_a.press_p, 4'b0000);
        chk("rst_release", bus_a.release_p, 4'b0000);
        chk("rst_any", bus_a.any_press, 1'b0);
        chk("rst_b_db", bus_b.db_level, 4'b0000);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        chk("idle_b_db", bus_b.db_level, 4'b0000);
        // single press latency and no auto-repeat
        bus_a.pb = 4'b0001;
        repeat (6) tick();
        chk("t1_early_press", bus_a.press_p, 4'b0000);
        chk("t1_early_db", bus_a.db_level, 4'b0000);
        tick();
        chk("t1_press", bus_a.press_p, 4'b0001);
        chk("t1_any", bus_a.any_press, 1'b1);
        chk("t1_db", bus_a.db_level, 4'b0001);
        chk("t1_rel", bus_a.release_p, 4'b0000);
        tick();
        chk("t1_press_end", bus_a.press_p, 4'b0000);
        chk("t1_any_end", bus_a.any_press, 1'b0);
        chk("t1_db_hold", bus_a.db_level, 4'b0001);
        np = 0;
        repeat (10) begin tick(); np += int'(bus_a.press_p[0]); end
        chk("t1_no_repeat", np, 0);
        // release latency
        bus_a.pb = 4'b0000;
        repeat (6) tick();
        chk("t3_early_rel", bus_a.release_p, 4'b0000);
        chk("t3_early_db", bus_a.db_level, 4'b0001);
        tick();
        chk("t3_rel", bus_a.release_p, 4'b0001);
        chk("t3_db", bus_a.db_level, 4'b0000);
        chk("t3_no_press", bus_a.press_p, 4'b0000);
        tick();
        chk("t3_rel_end", bus_a.release_p, 4'b0000);
        repeat (2) tick();
        // bouncing input never qualifies
        np = 0;
        db_hi = 0;
        foreach (bus_a.pb[i]) begin end
        for (int i = 0; i < 14; i++) begin
            bus_a.pb = (i < 6) ? {2'b00, 6'b011011 >> (5 - i) & 1'b1 ? 1'b1 : 1'b0, 1'b0} : 4'b0000;
            tick();
            np += int'(bus_a.press_p[1]);
            db_hi += int'(bus_a.db_level[1]);
        end
        chk("t2_no_press", np, 0);
        chk("t2_db_low", db_hi, 0);
        // short release glitch keeps the button pressed
        bus_a.pb = 4'b0001;
        repeat (7) tick();
        chk("t4_press", bus_a.press_p, 4'b0001);
        bus_a.pb = 4'b0000;
        repeat (2) tick();
        bus_a.pb = 4'b0001;
        np = 0;
        nr = 0;
        db_lo = 0;
        repeat (12) begin
            tick();
            np += int'(bus_a.press_p[0]);
            nr += int'(bus_a.release_p[0]);
            db_lo += int'(!bus_a.db_level[0]);
        end
        chk("t4_no_release", nr, 0);
        chk("t4_no_press", np, 0);
        chk("t4_db_held", db_lo, 0);
        bus_a.pb = 4'b0000;
        repeat (10) tick();
        chk("t4_released", bus_a.db_level, 4'b0000);
        // simultaneous press on two channels
        bus_a.pb = 4'b1001;
        repeat (7) tick();
        chk("t5_press", bus_a.press_p, 4'b1001);
        chk("t5_any", bus_a.any_press, 1'b1);
        tick();
        chk("t5_press_end", bus_a.press_p, 4'b0000);
        chk("t5_any_end", bus_a.any_press, 1'b0);
        bus_a.pb = 4'b0000;
        repeat (10) tick();
        // reset while pressed clears outputs asynchronously
        bus_a.pb = 4'b0001;
        repeat (8) tick();
        chk("t6_pressed", bus_a.db_level, 4'b0001);
        #2 rst_a = 1'b0;
        #1 chk("t6_async_db", bus_a.db_level, 4'b0000);
        tick();
        rst_a = 1'b1;
        // reset mid press-wait discards progress
        repeat (5) tick();
        rst_a = 1'b0;
        #1 chk("t6_pw_press", bus_a.press_p, 4'b0000);
        chk("t6_pw_db", bus_a.db_level, 4'b0000);
        rst_a = 1'b1;
        np = 0;
        repeat (6) begin tick(); np += int'(bus_a.press_p[0]); end
        chk("t6_no_early", np, 0);
        tick();
        chk("t6_repress", bus_a.press_p, 4'b0001);
        chk("t6_repress_db", bus_a.db_level, 4'b0001);
        // active-low polarity with reset mid press-wait
        bus_b.pb = 4'b1110;
        repeat (5) tick();
        rst_b = 1'b0;
        #1 chk("t7_rst_press", bus_b.press_p, 4'b0000);
        chk("t7_rst_db", bus_b.db_level, 4'b0000);
        rst_b = 1'b1;
        np = 0;
        repeat (6) begin tick(); np += int'(bus_b.press_p[0]); end
        chk("t7_no_early", np, 0);
        tick();
        chk("t7_press", bus_b.press_p, 4'b0001);
        chk("t7_db", bus_b.db_level, 4'b0001);
        chk("t7_any", bus_b.any_press, 1'b1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
